// File: rtl/gcm_ghash_tag_if.sv
// gcm_ghash_tag_if: start/key/length inputs, AAD+ciphertext block stream and tag handshake of the GHASH tag stage
interface gcm_ghash_tag_if;
    logic         i_start;
    logic [0:127] i_h;
    logic [0:127] i_ej0;
    logic [0:63]  i_len_aad;
    logic [0:63]  i_len_ct;
    logic         i_blk_valid;
    logic [0:127] i_blk;
    logic         o_blk_ready;
    logic         o_busy;
    logic         o_tag_valid;
    logic [0:127] o_tag;
    logic         i_tag_ready;

    modport master (
        output i_start, i_h, i_ej0, i_len_aad, i_len_ct, i_blk_valid, i_blk, i_tag_ready,
        input  o_blk_ready, o_busy, o_tag_valid, o_tag
    );

    modport slave (
        input  i_start, i_h, i_ej0, i_len_aad, i_len_ct, i_blk_valid, i_blk, i_tag_ready,
        output o_blk_ready, o_busy, o_tag_valid, o_tag
    );
endinterface

// File: rtl/gcm_ghash_tag.sv
// gcm_ghash_tag: iterative GHASH over AAD and ciphertext blocks plus the length block, tag = GHASH ^ E(K,J0)
module gcm_ghash_tag #(
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            i_rst,
    gcm_ghash_tag_if.slave bus
);
    localparam int MC = 128 / DIGIT;
    localparam logic [0:127] R = {8'he1, 120'd0};

    typedef enum logic [2:0] {IDLE, WAIT_BLK, MUL, LEN_MUL, DONE} state_t;

    state_t       r_state;
    logic [0:127] r_h, r_ej0, r_y, r_x, r_z, r_v, r_tag;
    logic [0:63]  r_len_aad, r_len_ct;
    logic [56:0]  r_n_aad, r_n_ct;
    logic [7:0]   r_cnt;
    logic         r_ld, r_tag_valid;
    logic [0:127] w_z, w_v, w_mask;
    logic [56:0]  w_na, w_nc;
    logic [6:0]   w_r;
    logic         w_last, w_more, w_aad, w_sec_last;

    function automatic logic [56:0] nblk(input logic [0:63] len);
        return len[0:56] + 57'(|len[57:63]);
    endfunction

    assign w_na       = nblk(bus.i_len_aad);
    assign w_nc       = nblk(bus.i_len_ct);
    assign w_last     = r_cnt == 8'(MC - 1);
    assign w_more     = |{r_n_aad, r_n_ct};
    assign w_aad      = |r_n_aad;
    assign w_sec_last = w_aad ? r_n_aad == 57'd1 : r_n_ct == 57'd1;
    assign w_r        = w_aad ? r_len_aad[57:63] : r_len_ct[57:63];
    assign w_mask     = (w_sec_last && |w_r) ? ~({128{1'b1}} >> w_r) : {128{1'b1}};

    assign bus.o_blk_ready = r_state == WAIT_BLK;
    assign bus.o_busy      = r_state != IDLE;
    assign bus.o_tag_valid = r_tag_valid;
    assign bus.o_tag       = r_tag;

    // One multiplier step: consume DIGIT bits of X (MSB first), accumulating V into Z and shifting V
    always_comb begin
        w_z = r_z;
        w_v = r_v;
        for (int j = 0; j < DIGIT; j++) begin
            w_z = r_x[j] ? w_z ^ w_v : w_z;
            w_v = w_v[127] ? (w_v >> 1) ^ R : w_v >> 1;
        end
    end

    // Control FSM with the GHASH datapath; the length block gets a load cycle like a data block
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_h         <= '0;
            r_ej0       <= '0;
            r_y         <= '0;
            r_x         <= '0;
            r_z         <= '0;
            r_v         <= '0;
            r_tag       <= '0;
            r_len_aad   <= '0;
            r_len_ct    <= '0;
            r_n_aad     <= '0;
            r_n_ct      <= '0;
            r_cnt       <= '0;
            r_ld        <= 1'b0;
            r_tag_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_start) begin
                    r_h       <= bus.i_h;
                    r_ej0     <= bus.i_ej0;
                    r_len_aad <= bus.i_len_aad;
                    r_len_ct  <= bus.i_len_ct;
                    r_n_aad   <= w_na;
                    r_n_ct    <= w_nc;
                    r_y       <= '0;
                    r_x       <= {bus.i_len_aad, bus.i_len_ct};
                    r_z       <= '0;
                    r_v       <= bus.i_h;
                    r_cnt     <= '0;
                    r_ld      <= 1'b0;
                    r_state   <= |{w_na, w_nc} ? WAIT_BLK : LEN_MUL;
                end
                WAIT_BLK: if (bus.i_blk_valid) begin
                    r_x     <= r_y ^ (bus.i_blk & w_mask);
                    r_z     <= '0;
                    r_v     <= r_h;
                    r_cnt   <= '0;
                    r_n_aad <= w_aad ? r_n_aad - 57'd1 : r_n_aad;
                    r_n_ct  <= w_aad ? r_n_ct : r_n_ct - 57'd1;
                    r_state <= MUL;
                end
                MUL: begin
                    r_z   <= w_z;
                    r_v   <= w_v;
                    r_x   <= r_x << DIGIT;
                    r_cnt <= r_cnt + 8'd1;
                    if (w_last) begin
                        r_y     <= w_z;
                        r_ld    <= !w_more;
                        r_state <= w_more ? WAIT_BLK : LEN_MUL;
                    end
                end
                LEN_MUL: if (r_ld) begin
                    r_x   <= r_y ^ {r_len_aad, r_len_ct};
                    r_z   <= '0;
                    r_v   <= r_h;
                    r_cnt <= '0;
                    r_ld  <= 1'b0;
                end else begin
                    r_z   <= w_z;
                    r_v   <= w_v;
                    r_x   <= r_x << DIGIT;
                    r_cnt <= r_cnt + 8'd1;
                    if (w_last) begin
                        r_y         <= w_z;
                        r_tag       <= w_z ^ r_ej0;
                        r_tag_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (bus.i_tag_ready) begin
                    r_tag_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
